// File: rtl/tt_mux_ctrl.sv
// tt_mux_ctrl: project-select controller feeding the mux address in tt_top.
// Synchronizes three slow async control pins, steps a select counter on
// increment edges, commits it to addr on an enable rising edge, then holds
// the selected design in reset for RST_CYCLES cycles before releasing it.
module tt_mux_ctrl #(
  parameter int ADDR_W      = 5,
  parameter int MAX_ADDR    = 31,
  parameter int SYNC_STAGES = 2,
  parameter int RST_CYCLES  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_sel_rst,
  input  logic              ctrl_sel_inc,
  input  logic              ctrl_ena,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] sel_cnt,
  output logic              design_rst_n,
  output logic              active
);

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] sel_rst_sync;
  logic [SYNC_STAGES-1:0] inc_sync;
  logic [SYNC_STAGES-1:0] ena_sync;
  logic                   inc_prev;
  logic                   ena_prev;
  logic [HOLD_W-1:0]      hold_cnt;

  logic sel_rst_s;
  logic inc_s;
  logic ena_s;
  logic inc_edge;
  logic ena_edge;

  assign sel_rst_s = sel_rst_sync[SYNC_STAGES-1];
  assign inc_s     = inc_sync[SYNC_STAGES-1];
  assign ena_s     = ena_sync[SYNC_STAGES-1];
  assign inc_edge  = inc_s & ~inc_prev;
  assign ena_edge  = ena_s & ~ena_prev;

  // Synchronizer chains plus one "previous" flop each for inc/ena edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_rst_sync <= '0;
      inc_sync     <= '0;
      ena_sync     <= '0;
      inc_prev     <= 1'b0;
      ena_prev     <= 1'b0;
    end else begin
      sel_rst_sync <= {sel_rst_sync[SYNC_STAGES-2:0], ctrl_sel_rst};
      inc_sync     <= {inc_sync[SYNC_STAGES-2:0], ctrl_sel_inc};
      ena_sync     <= {ena_sync[SYNC_STAGES-2:0], ctrl_ena};
      inc_prev     <= inc_s;
      ena_prev     <= ena_s;
    end
  end

  // Select FSM: counter only moves in IDLE, commit/hold/release sequencing, registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sel_cnt      <= '0;
      addr         <= '0;
      hold_cnt     <= '0;
      design_rst_n <= 1'b0;
      active       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          design_rst_n <= 1'b0;
          active       <= 1'b0;
          if (sel_rst_s) begin
            sel_cnt <= '0;
          end else if (inc_edge) begin
            sel_cnt <= (sel_cnt == ADDR_W'(MAX_ADDR)) ? '0 : sel_cnt + 1'b1;
          end
          if (ena_edge) begin
            addr     <= sel_cnt;
            hold_cnt <= HOLD_W'(RST_CYCLES - 1);
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (!ena_s) begin
            state        <= IDLE;
            design_rst_n <= 1'b0;
            active       <= 1'b0;
          end else if (hold_cnt == '0) begin
            state        <= ACTIVE;
            design_rst_n <= 1'b1;
            active       <= 1'b1;
          end else begin
            hold_cnt     <= hold_cnt - 1'b1;
            design_rst_n <= 1'b0;
            active       <= 1'b0;
          end
        end
        ACTIVE: begin
          if (!ena_s) begin
            state        <= IDLE;
            design_rst_n <= 1'b0;
            active       <= 1'b0;
          end else begin
            design_rst_n <= 1'b1;
            active       <= 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          design_rst_n <= 1'b0;
          active       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_mux_ctrl.sv
// tb_tt_mux_ctrl: directed, table-driven bench for tt_mux_ctrl with
// hand-computed expectations (SYNC_STAGES=2, RST_CYCLES=4, MAX_ADDR=31).
module tb_tt_mux_ctrl;

  logic       clk;
  logic       rst;
  logic       ctrl_sel_rst;
  logic       ctrl_sel_inc;
  logic       ctrl_ena;
  logic [4:0] addr;
  logic [4:0] sel_cnt;
  logic       design_rst_n;
  logic       active;

  int pass_count;
  int check_count;

  typedef struct {
    string      name;
    logic       do_clear;
    int         pulses;
    logic [4:0] exp_cnt;
  } vec_t;

  vec_t vecs[7];

  tt_mux_ctrl #(
    .ADDR_W(5),
    .MAX_ADDR(31),
    .SYNC_STAGES(2),
    .RST_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ctrl_sel_rst(ctrl_sel_rst),
    .ctrl_sel_inc(ctrl_sel_inc),
    .ctrl_ena(ctrl_ena),
    .addr(addr),
    .sel_cnt(sel_cnt),
    .design_rst_n(design_rst_n),
    .active(active)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n clock edges, landing 1 unit after the last rising edge
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
    end
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic doReset(input int n);
    rst = 1'b1;
    tick(n);
    rst = 1'b0;
  endtask

  // One increment pulse: 2 cycles high, 2 cycles low
  task automatic pulseInc(input int n);
    for (int i = 0; i < n; i++) begin
      ctrl_sel_inc = 1'b1;
      tick(2);
      ctrl_sel_inc = 1'b0;
      tick(2);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.do_clear) begin
      ctrl_sel_rst = 1'b1;
      tick(4);
      ctrl_sel_rst = 1'b0;
      tick(3);
    end
    pulseInc(v.pulses);
    tick(2);
    checkOutput({v.name, "_sel_cnt"}, 32'(sel_cnt), 32'(v.exp_cnt));
    checkOutput({v.name, "_addr"}, 32'(addr), 32'd0);
  endtask

  int active_seen;

  initial begin
    pass_count   = 0;
    check_count  = 0;
    rst          = 1'b1;
    ctrl_sel_rst = 1'b0;
    ctrl_sel_inc = 1'b0;
    ctrl_ena     = 1'b0;

    vecs[0] = '{"inc5",       1'b0, 5,  5'd5};
    vecs[1] = '{"inc3",       1'b0, 3,  5'd8};
    vecs[2] = '{"clear",      1'b1, 0,  5'd0};
    vecs[3] = '{"to_max",     1'b0, 31, 5'd31};
    vecs[4] = '{"wrap",       1'b0, 1,  5'd0};
    vecs[5] = '{"inc33",      1'b0, 33, 5'd1};
    vecs[6] = '{"clear_inc2", 1'b1, 2,  5'd2};

    // Reset state
    doReset(3);
    checkOutput("rst_addr", 32'(addr), 32'd0);
    checkOutput("rst_sel_cnt", 32'(sel_cnt), 32'd0);
    checkOutput("rst_design_rst_n", 32'(design_rst_n), 32'd0);
    checkOutput("rst_active", 32'(active), 32'd0);

    // Counter behaviour in IDLE from the table
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
    end

    // Commit 5, exact hold length, then release
    doReset(2);
    pulseInc(5);
    ctrl_ena = 1'b1;
    tick(3);
    checkOutput("commit_addr", 32'(addr), 32'd5);
    checkOutput("commit_rst_n_low", 32'(design_rst_n), 32'd0);
    tick(3);
    checkOutput("hold_last_rst_n", 32'(design_rst_n), 32'd0);
    checkOutput("hold_last_active", 32'(active), 32'd0);
    tick(1);
    checkOutput("release_rst_n", 32'(design_rst_n), 32'd1);
    checkOutput("release_active", 32'(active), 32'd1);

    // Counter frozen while ACTIVE, then disable
    pulseInc(3);
    tick(2);
    checkOutput("frozen_sel_cnt", 32'(sel_cnt), 32'd5);
    checkOutput("frozen_active", 32'(active), 32'd1);
    ctrl_ena = 1'b0;
    tick(2);
    checkOutput("disable_not_yet", 32'(active), 32'd1);
    tick(1);
    checkOutput("disable_active", 32'(active), 32'd0);
    checkOutput("disable_rst_n", 32'(design_rst_n), 32'd0);
    checkOutput("disable_addr", 32'(addr), 32'd5);
    checkOutput("disable_sel_cnt", 32'(sel_cnt), 32'd5);

    // sel_rst wins over a simultaneous inc edge
    pulseInc(2);
    tick(2);
    checkOutput("pre_prio_sel_cnt", 32'(sel_cnt), 32'd7);
    ctrl_sel_rst = 1'b1;
    ctrl_sel_inc = 1'b1;
    tick(4);
    ctrl_sel_rst = 1'b0;
    ctrl_sel_inc = 1'b0;
    tick(4);
    checkOutput("prio_sel_cnt", 32'(sel_cnt), 32'd0);

    // Enable dropped after two HOLD cycles: active must never assert
    doReset(2);
    ctrl_ena = 1'b1;
    tick(2);
    ctrl_ena = 1'b0;
    active_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (active) active_seen++;
    end
    checkOutput("abort_active_never", 32'(active_seen), 32'd0);
    checkOutput("abort_rst_n", 32'(design_rst_n), 32'd0);
    checkOutput("abort_addr", 32'(addr), 32'd0);

    // rst pulsed while ACTIVE, with ena still high afterwards
    pulseInc(3);
    ctrl_ena = 1'b1;
    tick(9);
    checkOutput("pre_rst_active", 32'(active), 32'd1);
    checkOutput("pre_rst_addr", 32'(addr), 32'd3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkOutput("midrst_addr", 32'(addr), 32'd0);
    checkOutput("midrst_sel_cnt", 32'(sel_cnt), 32'd0);
    checkOutput("midrst_rst_n", 32'(design_rst_n), 32'd0);
    checkOutput("midrst_active", 32'(active), 32'd0);
    tick(6);
    checkOutput("ena_held_not_yet", 32'(active), 32'd0);
    tick(1);
    checkOutput("ena_held_active", 32'(active), 32'd1);
    checkOutput("ena_held_addr", 32'(addr), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
